// File: rtl/feature_matcher_pkg.sv
// Shared widths and encodings for the feature matcher front end.
// Descriptor beat = 256 descriptor bits + 24 key/index bits; result beat = 64 bits.
package feature_matcher_pkg;

  localparam int DESC_BITS = 256;
  localparam int KEY_BITS  = 24;
  localparam int DESC_W    = DESC_BITS + KEY_BITS;
  localparam int RES_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Records which requester owns each outstanding matcher packet, oldest at the head.
// Zero-latency head read; push and pop in one cycle both take effect, count unchanged.
module order_fifo
  import feature_matcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head_id,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_id;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign head_id = req_id_t'(mem[rd_ptr[AW-1:0]]);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/matcher_arbiter.sv
// Packet-level round-robin share of one feature matcher between two requesters, results routed back in order.
// Data paths combinational (zero latency); one idle cycle per packet for arbitration; stalls grants when ORDER_DEPTH packets are outstanding.
module matcher_arbiter
  import feature_matcher_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = DESC_W,
  parameter int C_M_AXIS_TDATA_WIDTH = RES_W,
  parameter int ORDER_DEPTH          = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,

  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,

  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,

  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   mm_axis_tdata,
  output logic                              mm_axis_tvalid,
  output logic                              mm_axis_tlast,
  input  logic                              mm_axis_tready,

  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   mr_axis_tdata,
  input  logic                              mr_axis_tvalid,
  input  logic                              mr_axis_tlast,
  output logic                              mr_axis_tready,

  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   r0_axis_tdata,
  output logic                              r0_axis_tvalid,
  output logic                              r0_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] r0_axis_tkeep,
  input  logic                              r0_axis_tready,

  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   r1_axis_tdata,
  output logic                              r1_axis_tvalid,
  output logic                              r1_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] r1_axis_tkeep,
  input  logic                              r1_axis_tready,

  output logic                              busy
);

  arb_state_t state, state_nxt;
  req_id_t    prio, prio_nxt;
  logic       push;
  req_id_t    push_id;
  logic       pop;
  req_id_t    head_id;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      prio  <= REQ0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Grant decision uses the registered full flag, so a same-cycle pop does not free a slot yet.
  always_comb begin
    state_nxt      = state;
    prio_nxt       = prio;
    push           = 1'b0;
    push_id        = REQ0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    mm_axis_tdata  = '0;
    mm_axis_tvalid = 1'b0;
    mm_axis_tlast  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_full && (s0_axis_tvalid || s1_axis_tvalid)) begin
          push      = 1'b1;
          push_id   = (s0_axis_tvalid && s1_axis_tvalid) ? prio
                    : (s1_axis_tvalid ? REQ1 : REQ0);
          state_nxt = (push_id == REQ1) ? ST_GRANT1 : ST_GRANT0;
        end
      end
      ST_GRANT0: begin
        mm_axis_tdata  = s0_axis_tdata;
        mm_axis_tvalid = s0_axis_tvalid;
        mm_axis_tlast  = s0_axis_tlast;
        s0_axis_tready = mm_axis_tready;
        if (s0_axis_tvalid && mm_axis_tready && s0_axis_tlast) begin
          state_nxt = ST_IDLE;
          prio_nxt  = other_req(REQ0);
        end
      end
      ST_GRANT1: begin
        mm_axis_tdata  = s1_axis_tdata;
        mm_axis_tvalid = s1_axis_tvalid;
        mm_axis_tlast  = s1_axis_tlast;
        s1_axis_tready = mm_axis_tready;
        if (s1_axis_tvalid && mm_axis_tready && s1_axis_tlast) begin
          state_nxt = ST_IDLE;
          prio_nxt  = other_req(REQ1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result steering: only the requester at the FIFO head sees valid results.
  always_comb begin
    mr_axis_tready = 1'b0;
    r0_axis_tvalid = 1'b0;
    r0_axis_tlast  = 1'b0;
    r1_axis_tvalid = 1'b0;
    r1_axis_tlast  = 1'b0;
    if (!fifo_empty) begin
      if (head_id == REQ0) begin
        r0_axis_tvalid = mr_axis_tvalid;
        r0_axis_tlast  = mr_axis_tlast;
        mr_axis_tready = r0_axis_tready;
      end else begin
        r1_axis_tvalid = mr_axis_tvalid;
        r1_axis_tlast  = mr_axis_tlast;
        mr_axis_tready = r1_axis_tready;
      end
    end
  end

  assign r0_axis_tdata = mr_axis_tdata;
  assign r1_axis_tdata = mr_axis_tdata;
  assign r0_axis_tkeep = '1;
  assign r1_axis_tkeep = '1;

  assign pop  = mr_axis_tvalid && mr_axis_tready && mr_axis_tlast;
  assign busy = (state != ST_IDLE) || !fifo_empty;

  order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_matcher_arbiter.sv
// Directed bench for matcher_arbiter: expected beats queued at stimulus time, monitor pops and compares on each transfer.
module tb_matcher_arbiter;

  localparam int DW = 280;
  localparam int RW = 64;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s0_tdata, s1_tdata, mm_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          mm_tvalid, mm_tlast, mm_tready;
  logic [RW-1:0] mr_tdata, r0_tdata, r1_tdata;
  logic          mr_tvalid, mr_tlast, mr_tready;
  logic          r0_tvalid, r0_tlast, r0_tready;
  logic          r1_tvalid, r1_tlast, r1_tready;
  logic [7:0]    r0_tkeep, r1_tkeep;
  logic          busy;

  matcher_arbiter dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tready (s1_tready),
    .mm_axis_tdata  (mm_tdata),
    .mm_axis_tvalid (mm_tvalid),
    .mm_axis_tlast  (mm_tlast),
    .mm_axis_tready (mm_tready),
    .mr_axis_tdata  (mr_tdata),
    .mr_axis_tvalid (mr_tvalid),
    .mr_axis_tlast  (mr_tlast),
    .mr_axis_tready (mr_tready),
    .r0_axis_tdata  (r0_tdata),
    .r0_axis_tvalid (r0_tvalid),
    .r0_axis_tlast  (r0_tlast),
    .r0_axis_tkeep  (r0_tkeep),
    .r0_axis_tready (r0_tready),
    .r1_axis_tdata  (r1_tdata),
    .r1_axis_tvalid (r1_tvalid),
    .r1_axis_tlast  (r1_tlast),
    .r1_axis_tkeep  (r1_tkeep),
    .r1_axis_tready (r1_tready),
    .busy           (busy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW:0] mm_q[$];
  logic [RW:0] r0_q[$];
  logic [RW:0] r1_q[$];
  int          mm_cyc[$];

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic report_fail(input string name);
    n_chk++;
    $display("FAIL %s: got no event, expected one within bound", name);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expectation on that port.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (mm_tvalid && mm_tready) begin
        mm_cyc.push_back(cyc);
        if (mm_q.size() == 0) report_fail("mm_unexpected_beat");
        else check("mm_beat", {mm_tlast, mm_tdata}, mm_q.pop_front());
      end
      if (r0_tvalid && r0_tready) begin
        if (r0_q.size() == 0) report_fail("r0_unexpected_beat");
        else check("r0_beat", {r0_tlast, r0_tdata}, r0_q.pop_front());
      end
      if (r1_tvalid && r1_tready) begin
        if (r1_q.size() == 0) report_fail("r1_unexpected_beat");
        else check("r1_beat", {r1_tlast, r1_tdata}, r1_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_pkt(input int id, input int nbeats, input logic [DW-1:0] base);
    for (int b = 0; b < nbeats; b++) begin
      int  t;
      bit  hs;
      t  = 0;
      hs = 1'b0;
      if (id == 0) begin
        s0_tvalid = 1'b1; s0_tdata = base + DW'(b); s0_tlast = (b == nbeats - 1);
      end else begin
        s1_tvalid = 1'b1; s1_tdata = base + DW'(b); s1_tlast = (b == nbeats - 1);
      end
      while (!hs) begin
        @(negedge aclk);
        hs = (id == 0) ? s0_tready : s1_tready;
        @(posedge aclk);
        #1;
        t++;
        if (!hs && t > 200) begin
          report_fail("send_pkt_timeout");
          hs = 1'b1;
        end
      end
    end
    if (id == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    else         begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
  endtask

  task automatic send_res(input logic [RW-1:0] d, input logic last);
    int t;
    bit hs;
    t  = 0;
    hs = 1'b0;
    mr_tvalid = 1'b1; mr_tdata = d; mr_tlast = last;
    while (!hs) begin
      @(negedge aclk);
      hs = mr_tready;
      @(posedge aclk);
      #1;
      t++;
      if (!hs && t > 200) begin
        report_fail("send_res_timeout");
        hs = 1'b1;
      end
    end
    mr_tvalid = 1'b0; mr_tlast = 1'b0;
  endtask

  initial begin
    int c0;
    int stall;
    aresetn   = 1'b0;
    s0_tdata  = '0; s0_tvalid = 1'b1; s0_tlast = 1'b1;
    s1_tdata  = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    mr_tdata  = '0; mr_tvalid = 1'b1; mr_tlast = 1'b1;
    mm_tready = 1'b1; r0_tready = 1'b1; r1_tready = 1'b1;

    // Reset values, with live inputs that must not leak through
    tick(2);
    check("rst_s0_tready", s0_tready, 0);
    check("rst_s1_tready", s1_tready, 0);
    check("rst_mm_tvalid", mm_tvalid, 0);
    check("rst_mm_tlast",  mm_tlast,  0);
    check("rst_mr_tready", mr_tready, 0);
    check("rst_r0_tvalid", r0_tvalid, 0);
    check("rst_r1_tvalid", r1_tvalid, 0);
    check("rst_r0_tlast",  r0_tlast,  0);
    check("rst_r1_tlast",  r1_tlast,  0);
    check("rst_busy",      busy,      0);
    check("r0_tkeep",      r0_tkeep,  8'hFF);
    s0_tvalid = 1'b0; s0_tlast = 1'b0; mr_tvalid = 1'b0; mr_tlast = 1'b0;
    aresetn = 1'b1;
    tick(1);

    // Completed s0 packet moves prio to 1; then reset in beat 2 of a 4-beat packet
    mm_q.push_back({1'b1, DW'('h11)});
    send_pkt(0, 1, DW'('h11));
    mm_q.push_back({1'b0, DW'('h20)});
    s0_tvalid = 1'b1; s0_tdata = DW'('h20); s0_tlast = 1'b0;
    tick(1);
    tick(1);
    s0_tdata = DW'('h21);
    #1 aresetn = 1'b0;
    #1;
    check("midrst_s0_tready", s0_tready, 0);
    check("midrst_mm_tvalid", mm_tvalid, 0);
    check("midrst_busy",      busy,      0);
    @(posedge aclk); #1;
    s0_tvalid = 1'b0;
    aresetn = 1'b1;
    tick(1);
    check("postrst_busy",      busy,      0);
    check("postrst_mm_tvalid", mm_tvalid, 0);
    check("postrst_mm_drained", mm_q.size(), 0);

    // Both valid: prio 0 after reset, so s0 then one bubble then s1
    for (int b = 0; b < 3; b++) mm_q.push_back({b == 2, DW'('h30 + b)});
    for (int b = 0; b < 3; b++) mm_q.push_back({b == 2, DW'('h40 + b)});
    mm_cyc.delete();
    c0 = cyc;
    fork
      send_pkt(0, 3, DW'('h30));
      send_pkt(1, 3, DW'('h40));
    join
    check("rr_beat_count", mm_cyc.size(), 6);
    if (mm_cyc.size() == 6) begin
      int exp_off[6] = '{1, 2, 3, 5, 6, 7};
      for (int i = 0; i < 6; i++) check("rr_beat_cycle", mm_cyc[i] - c0, exp_off[i]);
    end

    // Results routed by order FIFO: 0 then 1
    r0_q.push_back({1'b0, 64'hA1}); r0_q.push_back({1'b1, 64'hA2});
    r1_q.push_back({1'b0, 64'hB1}); r1_q.push_back({1'b1, 64'hB2});
    send_res(64'hA1, 1'b0); send_res(64'hA2, 1'b1);
    send_res(64'hB1, 1'b0); send_res(64'hB2, 1'b1);
    check("route_busy_drops", busy, 0);
    mr_tvalid = 1'b1; mr_tdata = 64'hEE; mr_tlast = 1'b1;
    #1;
    check("empty_mr_tready", mr_tready, 0);
    check("empty_r0_tvalid", r0_tvalid, 0);
    check("empty_r1_tvalid", r1_tvalid, 0);
    mr_tvalid = 1'b0; mr_tlast = 1'b0;
    check("route_r0_q_empty", r0_q.size(), 0);
    check("route_r1_q_empty", r1_q.size(), 0);
    tick(1);

    // Four s1 packets fill the FIFO; the fifth stalls until a result pops
    for (int i = 0; i < 4; i++) begin
      mm_q.push_back({1'b1, DW'('h50 + i)});
      send_pkt(1, 1, DW'('h50 + i));
    end
    s1_tvalid = 1'b1; s1_tdata = DW'('h54); s1_tlast = 1'b1;
    stall = 0;
    repeat (6) begin
      @(negedge aclk);
      if (s1_tready) stall++;
    end
    check("full_stall_tready", stall, 0);
    check("full_busy", busy, 1);
    @(posedge aclk); #1;
    mm_q.push_back({1'b1, DW'('h54)});
    r1_q.push_back({1'b1, 64'hD0});
    mm_cyc.delete();
    c0 = cyc;
    fork
      send_pkt(1, 1, DW'('h54));
      send_res(64'hD0, 1'b1);
    join
    check("full_grant_after_pop_cycle", (mm_cyc.size() > 0) ? mm_cyc[0] - c0 : -1, 2);
    for (int i = 0; i < 4; i++) begin
      r1_q.push_back({1'b1, 64'hD1 + 64'(i)});
      send_res(64'hD1 + 64'(i), 1'b1);
    end
    check("full_drain_busy", busy, 0);

    // r0 back-pressure holds the result while s1 keeps streaming
    mm_q.push_back({1'b1, DW'('h60)});
    send_pkt(0, 1, DW'('h60));
    r0_tready = 1'b0;
    mr_tvalid = 1'b1; mr_tdata = 64'hC1; mr_tlast = 1'b1;
    mm_q.push_back({1'b0, DW'('h70)});
    mm_q.push_back({1'b1, DW'('h71)});
    fork
      send_pkt(1, 2, DW'('h70));
      repeat (4) begin
        @(negedge aclk);
        check("bp_mr_tready", mr_tready, 0);
        check("bp_r0_tvalid", r0_tvalid, 1);
        check("bp_r0_tdata",  r0_tdata,  64'hC1);
      end
    join
    check("bp_s1_streamed", mm_q.size(), 0);
    @(posedge aclk); #1;
    r0_q.push_back({1'b1, 64'hC1});
    r0_tready = 1'b1;
    tick(1);
    mr_tvalid = 1'b0; mr_tlast = 1'b0;
    r1_q.push_back({1'b1, 64'hC2});
    send_res(64'hC2, 1'b1);
    check("bp_busy_drops", busy, 0);

    // Same-cycle push and pop with three entries outstanding
    for (int i = 0; i < 3; i++) begin
      mm_q.push_back({1'b1, DW'('h80 + i)});
      send_pkt(0, 1, DW'('h80 + i));
    end
    mm_q.push_back({1'b1, DW'('h90)});
    r0_q.push_back({1'b1, 64'hE0});
    mm_cyc.delete();
    c0 = cyc;
    fork
      send_pkt(1, 1, DW'('h90));
      send_res(64'hE0, 1'b1);
    join
    check("pushpop_no_stall", (mm_cyc.size() > 0) ? mm_cyc[0] - c0 : -1, 1);
    r0_q.push_back({1'b1, 64'hE1});
    r0_q.push_back({1'b1, 64'hE2});
    r1_q.push_back({1'b1, 64'hE3});
    send_res(64'hE1, 1'b1);
    send_res(64'hE2, 1'b1);
    send_res(64'hE3, 1'b1);
    check("pushpop_busy_drops", busy, 0);
    check("end_mm_q_empty", mm_q.size(), 0);
    check("end_r0_q_empty", r0_q.size(), 0);
    check("end_r1_q_empty", r1_q.size(), 0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
